bpu_btb: RTL and testbench

- Parametrised next-PC generator for the pipeline CPU's IF stage. It succeeds the fixed dynamic predictor with a configurable-depth branch target buffer and per-entry N-bit saturating counters.
- Predicts taken branches from the current fetch PC and applies resolved-branch updates from EX.
- A mispredicted EX outcome overrides the prediction and raises a flush.
- Carries saturating performance counters for resolved branches and mispredicts.

---
 rtl/bpu_btb.sv | 153 +++++++++++++++
 tb/tb_bpu_btb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb.sv
// Branch target buffer next-PC generator for the IF stage.
// Direct-mapped table indexed by fetch PC, with per-entry saturating direction
// counters, a resolved-branch update path from EX, mispredict redirect, and
// saturating performance counters for resolved branches and mispredicts.
module bpu_btb #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pc_next,
    input  logic             upd_en,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispredict,
    output logic             flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    // Counter encodings: saturation ceiling, weakly taken, weakly not-taken.
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(32'd1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Table storage
    logic                 valid_r  [ENTRIES];
    logic [TAG_W-1:0]     tag_r    [ENTRIES];
    logic [31:0]          target_r [ENTRIES];
    logic [CTR_W-1:0]     ctr_r    [ENTRIES];
    logic [CNT_W-1:0]     br_cnt_r;
    logic [CNT_W-1:0]     miss_cnt_r;

    // Lookup and update decode
    logic [IDX_W-1:0]     li_s;
    logic [TAG_W-1:0]     lt_s;
    logic                 hit_s;
    logic                 taken_s;
    logic [IDX_W-1:0]     ui_s;
    logic [TAG_W-1:0]     ut_s;
    logic                 uhit_s;
    logic                 upd_fire_s;
    logic [CTR_W-1:0]     ctr_upd_s;
    logic                 flush_s;
    logic [31:0]          pc_next_s;

    assign li_s       = if_pc[IDX_W+1:2];
    assign lt_s       = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ui_s       = upd_pc[IDX_W+1:2];
    assign ut_s       = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_fire_s = upd_en & ~stall;

    // Zero-latency lookup against the current (pre-update) table contents.
    always_comb begin
        hit_s   = 1'b0;
        taken_s = 1'b0;
        if (valid_r[li_s] && (tag_r[li_s] == lt_s)) begin
            hit_s   = 1'b1;
            taken_s = ctr_r[li_s][CTR_W-1];
        end else begin
            hit_s   = 1'b0;
            taken_s = 1'b0;
        end
    end

    // Hit detection at the update index and the saturating counter step.
    always_comb begin
        uhit_s    = valid_r[ui_s] && (tag_r[ui_s] == ut_s);
        ctr_upd_s = ctr_r[ui_s];
        if (upd_taken) begin
            if (ctr_r[ui_s] != CTR_MAX) begin
                ctr_upd_s = ctr_r[ui_s] + CTR_W'(32'd1);
            end else begin
                ctr_upd_s = ctr_r[ui_s];
            end
        end else begin
            if (ctr_r[ui_s] != {CTR_W{1'b0}}) begin
                ctr_upd_s = ctr_r[ui_s] - CTR_W'(32'd1);
            end else begin
                ctr_upd_s = ctr_r[ui_s];
            end
        end
    end

    // Redirect selection: EX mispredict first, then a taken prediction, else sequential.
    always_comb begin
        flush_s   = upd_en & upd_mispredict;
        pc_next_s = if_pc + 32'd4;
        if (flush_s) begin
            pc_next_s = upd_taken ? upd_target : (upd_pc + 32'd4);
        end else if (taken_s) begin
            pc_next_s = target_r[li_s];
        end else begin
            pc_next_s = if_pc + 32'd4;
        end
    end

    // Table write: train on a hit, allocate on a taken miss, ignore a not-taken miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= 32'd0;
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (upd_fire_s) begin
            if (uhit_s) begin
                ctr_r[ui_s] <= ctr_upd_s;
                if (upd_taken) begin
                    target_r[ui_s] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_r[ui_s]  <= 1'b1;
                tag_r[ui_s]    <= ut_s;
                target_r[ui_s] <= upd_target;
                ctr_r[ui_s]    <= CTR_WT;
            end
        end
    end

    // Performance counters, saturating at all-ones so they never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_r   <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else if (upd_fire_s) begin
            if (br_cnt_r != CNT_MAX) begin
                br_cnt_r <= br_cnt_r + CNT_W'(32'd1);
            end
            if (upd_mispredict && (miss_cnt_r != CNT_MAX)) begin
                miss_cnt_r <= miss_cnt_r + CNT_W'(32'd1);
            end
        end
    end

    assign pred_hit   = hit_s;
    assign pred_taken = taken_s;
    assign pc_next    = pc_next_s;
    assign flush      = flush_s;
    assign br_cnt     = br_cnt_r;
    assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_bpu_btb.sv
// Self-checking bench for bpu_btb: directed scenarios followed by randomized
// traffic, all compared against a behavioural table model.
module tb_bpu_btb;

    localparam int CNT_W = 4;
    localparam int NENT  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [31:0]      if_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [31:0]      pc_next;
    logic             upd_en;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_mispredict;
    logic             flush;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    always #5 clk = ~clk;

    bpu_btb #(.ENTRIES(16), .IDX_W(4), .TAG_W(8), .CTR_W(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pc_next(pc_next),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    // Reference model state
    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    int          m_br;
    int          m_miss;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % NENT;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / 64) % 256;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic model_apply();
        int unsigned i;
        bit hit;
        if (!upd_en || stall) return;
        i   = idx_of(upd_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
        if (hit) begin
            if (upd_taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = upd_target;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = 2;
        end
        m_br = (m_br < 15) ? m_br + 1 : 15;
        if (upd_mispredict) m_miss = (m_miss < 15) ? m_miss + 1 : 15;
    endtask

    task automatic check_outputs();
        int unsigned i;
        bit e_hit, e_taken, e_flush;
        logic [31:0] e_pc;
        i       = idx_of(if_pc);
        e_hit   = m_valid[i] && (m_tag[i] == tag_of(if_pc));
        e_taken = e_hit && (m_ctr[i] >= 2);
        e_flush = upd_en && upd_mispredict;
        if (e_flush)      e_pc = upd_taken ? upd_target : upd_pc + 32'd4;
        else if (e_taken) e_pc = m_tgt[i];
        else              e_pc = if_pc + 32'd4;
        check_eq("pred_hit",   {31'd0, pred_hit},   {31'd0, e_hit});
        check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
        check_eq("flush",      {31'd0, flush},      {31'd0, e_flush});
        check_eq("pc_next",    pc_next,             e_pc);
        check_eq("br_cnt",     32'(br_cnt),         32'(m_br));
        check_eq("miss_cnt",   32'(miss_cnt),       32'(m_miss));
    endtask

    task automatic drive(input logic [31:0] pc, input logic en, input logic [31:0] upc,
                         input logic tk, input logic [31:0] tgt, input logic mp, input logic st);
        if_pc          = pc;
        upd_en         = en;
        upd_pc         = upc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mp;
        stall          = st;
    endtask

    // Check outputs mid-cycle, then advance one clock and update the model.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        if (rst) model_apply();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] t, ix;
        ix = 32'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0:       t = 32'h04;
            1:       t = 32'h14;
            2:       t = 32'hFF;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
        return (t << 6) | (ix << 2) | ({$urandom} & 32'hFFFF_C000);
    endfunction

    initial begin
        rst = 1'b0;
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h900, 1'b1, 1'b0);
        model_reset();
        @(negedge clk);
        // Reset held with an update pending: redirect still visible, no table write.
        step();
        rst = 1'b1;

        // Cold lookup
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Allocation with mispredict redirect, then hit on the next cycle
        drive(32'h300, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
        step();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Counter walk: three not-taken, four taken
        for (int k = 0; k < 7; k++) begin
            drive(32'h100, 1'b1, 32'h100, (k >= 3), 32'h200, 1'b0, 1'b0);
            step();
        end
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Aliasing at index 0
        drive(32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(32'h500, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0);
        step();
        drive(32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Address wrap on both sequential paths
        drive(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(32'h40, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b0);
        step();

        // Stall gating: three stalled cycles, then one release
        for (int k = 0; k < 4; k++) begin
            drive(32'h100, 1'b1, 32'h700, 1'b1, 32'h740, 1'b1, (k < 3));
            step();
        end
        drive(32'h700, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Fresh reset, then perf counter saturation
        rst = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(32'h300, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 1'b0);
            step();
        end
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Asynchronous reset mid-cycle, observed before any clock edge
        #1;
        check_outputs();
        #1;
        rst = 1'b0;
        #1;
        check_eq("async_hit",  {31'd0, pred_hit}, 32'd0);
        check_eq("async_br",   32'(br_cnt),       32'd0);
        check_eq("async_miss", 32'(miss_cnt),     32'd0);
        check_eq("async_pc",   pc_next,           32'h104);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            drive(rand_pc(), ($urandom_range(0, 1) == 1), rand_pc(), ($urandom_range(0, 2) != 0),
                  $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
